// File: rtl/cmd_proc_pkg.sv
// Shared definitions for the command processor.
//   cmd_state_t  : command FSM state encoding
//   CMD_RD_BIT   : opcode bit position in the command byte (1 = read)
//   word_bytes() : bytes per register word for a given word width
//   cnt_width()  : counter width able to index n items (minimum 1 bit)
package cmd_proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    WRITE,
    RD_REQ,
    RD_CAP,
    RESP
  } cmd_state_t;

  localparam int CMD_RD_BIT = 7;

  function automatic int word_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmd_proc_ser.sv
// Byte-wide, MSB-first response serialiser.
// A load pulse captures a full word and raises rsp_rts; each accepted byte
// (rsp_rts && rsp_rtr) advances to the next byte; the accepted last byte
// drops rsp_rts. The presented byte holds while not accepted.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   load, load_data     : parallel load of the word to send
//   rsp_rtr             : downstream accepts the presented byte
//   rsp_rts, rsp_data   : byte available / byte value
//   last                : presented byte is the final byte of the word
module cmd_proc_ser
  import cmd_proc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              rsp_rtr,
  output logic              rsp_rts,
  output logic [7:0]        rsp_data,
  output logic              last
);

  localparam int WB    = word_bytes(DATA_W);
  localparam int CNT_W = cnt_width(WB);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WB - 1);

  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  idx_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q <= '0;
      idx_q   <= '0;
      rsp_rts <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      idx_q   <= '0;
      rsp_rts <= 1'b1;
    end else if (rsp_rts && rsp_rtr) begin
      if (idx_q == LAST_IDX) begin
        rsp_rts <= 1'b0;
      end else begin
        shift_q <= shift_q << 8;
        idx_q   <= idx_q + CNT_W'(1);
      end
    end
  end

  assign rsp_data = shift_q[DATA_W-1 -: 8];
  assign last     = (idx_q == LAST_IDX);

endmodule

// File: rtl/cmd_proc_mc.sv
// Command processor between the host receive FIFO and the register file.
// Consumes a command byte (bit7 = read, low ADDR_W bits = address) followed,
// for writes, by DATA_W/8 data bytes MSB first. Writes issue REG_WE, reads
// issue REG_RE and return the read word as MSB-first bytes on RSP_*.
// Out-of-range addresses suppress the strobe and pulse CMD_ERR; such reads
// return zero.
// Optional build macro: CMD_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CYC cycles while collecting write data.
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   HOST_RTS, HOST_DATA, HOST_RTR : host byte stream in
//   REG_WE, REG_RE, REG_ADDR,
//   REG_WDATA, REG_RDATA          : register file access
//   RSP_RTS, RSP_RTR, RSP_DATA    : response byte stream out
//   CMD_ERR                       : one-cycle error pulse
module cmd_proc_mc
  import cmd_proc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int NUM_REGS    = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              HOST_RTS,
  input  logic [7:0]        HOST_DATA,
  output logic              HOST_RTR,
  output logic              REG_WE,
  output logic              REG_RE,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [DATA_W-1:0] REG_WDATA,
  input  logic [DATA_W-1:0] REG_RDATA,
  output logic              RSP_RTS,
  input  logic              RSP_RTR,
  output logic [7:0]        RSP_DATA,
  output logic              CMD_ERR
);

  localparam int WB    = word_bytes(DATA_W);
  localparam int CNT_W = cnt_width(WB);
  localparam logic [CNT_W-1:0] LAST_BYTE    = CNT_W'(WB - 1);
  localparam logic [ADDR_W:0]  NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  // Compare one bit wider than the address so NUM_REGS = 2**ADDR_W works.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_EXT);
  endfunction

  cmd_state_t        state, state_nxt;
  logic              rst_done;
  logic              host_xfer;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rd;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] word_next;
  logic              we_nxt, re_nxt, err_nxt;
  logic              ser_load;
  logic [DATA_W-1:0] ser_din;
  logic              ser_last;
  logic              tmo_hit;
  logic              unused_bits;

  // HOST_RTR is held low until the first cycle after reset is released.
  assign HOST_RTR  = rst_done && ((state == IDLE) || (state == DATA));
  assign host_xfer = HOST_RTS && HOST_RTR;
  assign cmd_addr  = HOST_DATA[ADDR_W-1:0];
  assign cmd_rd    = HOST_DATA[CMD_RD_BIT];
  assign word_next = (wdata_sh << 8) | DATA_W'(HOST_DATA);

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = cnt_width(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if ((state != DATA) || host_xfer) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit     = (state == DATA) && !host_xfer && (tmo_cnt == TMO_LAST);
  assign unused_bits = ^HOST_DATA;
`else
  assign tmo_hit     = 1'b0;
  assign unused_bits = ^{HOST_DATA, 32'(TIMEOUT_CYC)};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    re_nxt    = 1'b0;
    err_nxt   = 1'b0;
    ser_load  = 1'b0;
    ser_din   = '0;
    case (state)
      IDLE: begin
        if (host_xfer) begin
          if (cmd_rd) begin
            state_nxt = RD_REQ;
            if (addr_ok(cmd_addr)) re_nxt = 1'b1;
            else                   err_nxt = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (host_xfer && (byte_cnt == LAST_BYTE)) begin
          state_nxt = WRITE;
          if (addr_ok(addr_q)) we_nxt = 1'b1;
          else                 err_nxt = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      WRITE:  state_nxt = IDLE;
      RD_REQ: state_nxt = RD_CAP;
      RD_CAP: begin
        ser_load  = 1'b1;
        ser_din   = addr_ok(addr_q) ? REG_RDATA : '0;
        state_nxt = RESP;
      end
      RESP: begin
        if (RSP_RTS && RSP_RTR && ser_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered one cycle after the deciding host transfer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rst_done  <= 1'b0;
      REG_WE    <= 1'b0;
      REG_RE    <= 1'b0;
      CMD_ERR   <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      addr_q    <= '0;
      byte_cnt  <= '0;
    end else begin
      rst_done <= 1'b1;
      REG_WE   <= we_nxt;
      REG_RE   <= re_nxt;
      CMD_ERR  <= err_nxt;
      if (we_nxt) begin
        REG_ADDR  <= addr_q;
        REG_WDATA <= word_next;
      end else if (re_nxt) begin
        REG_ADDR <= cmd_addr;
      end
      if ((state == IDLE) && host_xfer) addr_q <= cmd_addr;
      if (state == IDLE) begin
        byte_cnt <= '0;
      end else if ((state == DATA) && host_xfer) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  // Partial write word; stale content is fully shifted out by a new command.
  always_ff @(posedge clk) begin
    if ((state == DATA) && host_xfer) wdata_sh <= word_next;
  end

  cmd_proc_ser #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ser_load),
    .load_data(ser_din),
    .rsp_rtr  (RSP_RTR),
    .rsp_rts  (RSP_RTS),
    .rsp_data (RSP_DATA),
    .last     (ser_last)
  );

endmodule

// File: tb/tb_cmd_proc_mc.sv
// Self-checking bench for cmd_proc_mc (DATA_W=32, ADDR_W=4, NUM_REGS=12).
module tb_cmd_proc_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        HOST_RTS;
  logic [7:0]  HOST_DATA;
  logic        HOST_RTR;
  logic        REG_WE;
  logic        REG_RE;
  logic [3:0]  REG_ADDR;
  logic [31:0] REG_WDATA;
  logic [31:0] REG_RDATA;
  logic        RSP_RTS;
  logic        RSP_RTR;
  logic [7:0]  RSP_DATA;
  logic        CMD_ERR;

  always #5 clk = ~clk;

  cmd_proc_mc #(
    .DATA_W(32), .ADDR_W(4), .NUM_REGS(12), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .HOST_RTS(HOST_RTS), .HOST_DATA(HOST_DATA), .HOST_RTR(HOST_RTR),
    .REG_WE(REG_WE), .REG_RE(REG_RE), .REG_ADDR(REG_ADDR),
    .REG_WDATA(REG_WDATA), .REG_RDATA(REG_RDATA),
    .RSP_RTS(RSP_RTS), .RSP_RTR(RSP_RTR), .RSP_DATA(RSP_DATA),
    .CMD_ERR(CMD_ERR)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] wdata;
    logic [31:0] rdval;
    int          exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int err_exp = 0;
  int rsp_xfers = 0;

  logic [35:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [7:0]  exp_rsp[$];
  logic [31:0] mem[16];

  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_unexp(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: strobe seen with nothing expected", name);
  endfunction

  // Register file model; drives a junk pattern when no read is issued.
  always @(posedge clk) REG_RDATA <= REG_RE ? mem[REG_ADDR] : 32'hA5A5_A5A5;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (REG_WE) begin
        if (exp_wr.size() == 0) fail_unexp("reg_we");
        else chk("reg_write", {28'h0, REG_ADDR, REG_WDATA}, {28'h0, exp_wr.pop_front()});
      end
      if (REG_RE) begin
        if (exp_rd.size() == 0) fail_unexp("reg_re");
        else chk("reg_read_addr", {60'h0, REG_ADDR}, {60'h0, exp_rd.pop_front()});
      end
      if (prev_hold) chk("rsp_hold", {55'h0, RSP_RTS, RSP_DATA}, {55'h0, 1'b1, prev_data});
      if (RSP_RTS) chk("rtr_in_resp", {63'h0, HOST_RTR}, 64'h0);
      if (RSP_RTS && RSP_RTR) begin
        rsp_xfers++;
        if (exp_rsp.size() == 0) fail_unexp("rsp_byte");
        else chk("rsp_byte", {56'h0, RSP_DATA}, {56'h0, exp_rsp.pop_front()});
      end
      if (CMD_ERR) err_seen++;
      prev_hold <= RSP_RTS && !RSP_RTR;
      prev_data <= RSP_DATA;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    HOST_DATA = b;
    HOST_RTS  = 1'b1;
    while (!HOST_RTR && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("host_accept_timeout", 64'(t), 64'h0);
    @(posedge clk); #1;
    HOST_RTS = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] a;
    bit         ok;
    a  = v.cmd[3:0];
    ok = (a < 4'd12);
    err_exp += v.exp_err;
    if (v.cmd[7]) begin
      mem[a] = v.rdval;
      if (ok) exp_rd.push_back(a);
      for (int i = 0; i < 4; i++) exp_rsp.push_back(ok ? v.rdval[31-8*i -: 8] : 8'h00);
      send_byte(v.cmd);
    end else begin
      if (ok) exp_wr.push_back({a, v.wdata});
      send_byte(v.cmd);
      for (int i = 0; i < 4; i++) send_byte(v.wdata[31-8*i -: 8]);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while (!(HOST_RTR && !RSP_RTS) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk({name, "_idle_timeout"}, 64'(t), 64'h0);
    repeat (2) @(negedge clk);
    chk({name, "_err_cnt"}, 64'(err_seen), 64'(err_exp));
  endtask

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vec_t v;

    tbl[0] = '{8'h22, 32'h1122_3344, 32'h0, 0};
    tbl[1] = '{8'hA2, 32'h0, 32'hDEAD_BEEF, 0};
    tbl[2] = '{8'h0E, 32'h0102_0304, 32'h0, 1};
    tbl[3] = '{8'h8D, 32'h0, 32'h1234_5678, 1};
    tbl[4] = '{8'h7B, 32'hCAFE_F00D, 32'h0, 0};
    tbl[5] = '{8'hCB, 32'h0, 32'h0BAD_F00D, 0};
    tbl[6] = '{8'h0C, 32'h55AA_55AA, 32'h0, 1};
    tbl[7] = '{8'h80, 32'h0, 32'hFFFF_FFFF, 0};
    tbl[8] = '{8'h1F, 32'h7777_8888, 32'h0, 1};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    reset_n   = 1'b0;
    HOST_RTS  = 1'b0;
    HOST_DATA = 8'h00;
    RSP_RTR   = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_host_rtr", {63'h0, HOST_RTR}, 64'h0);
    chk("rst_reg_we", {63'h0, REG_WE}, 64'h0);
    chk("rst_reg_re", {63'h0, REG_RE}, 64'h0);
    chk("rst_reg_addr", {60'h0, REG_ADDR}, 64'h0);
    chk("rst_reg_wdata", {32'h0, REG_WDATA}, 64'h0);
    chk("rst_rsp_rts", {63'h0, RSP_RTS}, 64'h0);
    chk("rst_rsp_data", {56'h0, RSP_DATA}, 64'h0);
    chk("rst_cmd_err", {63'h0, CMD_ERR}, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rtr_before_release", {63'h0, HOST_RTR}, 64'h0);
    @(negedge clk);
    chk("rtr_after_release", {63'h0, HOST_RTR}, 64'h1);

    // Write timing: strobe one cycle after last byte, RTR low only then.
    run_vec(tbl[0]);
    @(negedge clk);
    chk("wr_we_cycle", {63'h0, REG_WE}, 64'h1);
    chk("wr_rtr_low", {63'h0, HOST_RTR}, 64'h0);
    @(negedge clk);
    chk("wr_we_single", {63'h0, REG_WE}, 64'h0);
    chk("wr_rtr_back", {63'h0, HOST_RTR}, 64'h1);
    wait_idle("wr_timing");

    // Read timing: RE at N+1, first RSP_RTS at N+3, WORD_BYTES response cycles.
    run_vec(tbl[1]);
    @(negedge clk);
    chk("rd_re_cycle", {63'h0, REG_RE}, 64'h1);
    chk("rd_re_addr", {60'h0, REG_ADDR}, 64'h2);
    chk("rd_rts_n1", {63'h0, RSP_RTS}, 64'h0);
    @(negedge clk);
    chk("rd_rts_n2", {63'h0, RSP_RTS}, 64'h0);
    @(negedge clk);
    chk("rd_rts_n3", {63'h0, RSP_RTS}, 64'h1);
    chk("rd_first_byte", {56'h0, RSP_DATA}, 64'hDE);
    cnt = 1;
    @(negedge clk);
    while (RSP_RTS && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("rd_resp_cycles", 64'(cnt), 64'h4);
    wait_idle("rd_timing");

    // Table of writes/reads including out-of-range, junk bits and boundaries.
    for (int i = 2; i < 9; i++) begin
      run_vec(tbl[i]);
      wait_idle($sformatf("vec%0d", i));
    end

    // Backpressure on the response path.
    rsp_xfers = 0;
    v = '{8'h85, 32'h0, 32'hA1B2_C3D4, 0};
    fork
      begin
        run_vec(v);
        wait_idle("bp");
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          RSP_RTR = ((i % 4) == 0) || ((i % 4) == 3);
        end
      end
    join
    RSP_RTR = 1'b1;
    chk("bp_xfers", 64'(rsp_xfers), 64'h4);

    // Reset in the middle of a write command.
    send_byte(8'h23);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_rtr_low", {63'h0, HOST_RTR}, 64'h0);
    v = '{8'h25, 32'h0123_4567, 32'h0, 0};
    run_vec(v);
    wait_idle("midrst");

`ifdef CMD_TIMEOUT_EN
    // Inter-byte timeout while collecting write data.
    send_byte(8'h23);
    send_byte(8'hAA);
    err_exp += 1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!CMD_ERR && cnt < 1200);
    chk("tmo_latency", 64'(cnt), 64'd1025);
    @(negedge clk);
    chk("tmo_err_single", {63'h0, CMD_ERR}, 64'h0);
    chk("tmo_rtr_idle", {63'h0, HOST_RTR}, 64'h1);
    v = '{8'h23, 32'h89AB_CDEF, 32'h0, 0};
    run_vec(v);
    wait_idle("tmo_after");
`endif

    chk("sb_wr_empty", 64'(exp_wr.size()), 64'h0);
    chk("sb_rd_empty", 64'(exp_rd.size()), 64'h0);
    chk("sb_rsp_empty", 64'(exp_rsp.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
